// File: rtl/seq_divider.sv
// Sequential 8/4 unsigned restoring divider, one quotient bit per clock, MSB first.
// Define DIVZERO_CHK_EN to short-circuit y=0 into an immediate flagged result.
module seq_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] x_i,
    input  logic [3:0] y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] q_o,
    output logic [3:0] r_o,
    output logic       dz_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] div_q, div_d;
    logic [3:0] part_q, part_d;
    logic [7:0] quo_q, quo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] q_q, q_d;
    logic [3:0] r_q, r_d;
`ifdef DIVZERO_CHK_EN
    logic       dz_q, dz_d;
`endif

    logic [4:0] part_sh;
    logic [3:0] diff;
    logic       sub_ok;
    logic [3:0] part_nx;
    logic [7:0] quo_nx;

    // The true partial remainder is always below 16 once restored, so a 4-bit
    // difference suffices; bit 4 of the shifted value alone guarantees part >= y.
    always_comb begin
        part_sh = {part_q, dvd_q[7]};
        diff    = part_sh[3:0] - div_q;
        sub_ok  = part_sh[4] | (part_sh[3:0] >= div_q);
        part_nx = sub_ok ? diff : part_sh[3:0];
        quo_nx  = {quo_q[6:0], sub_ok};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        div_d   = div_q;
        part_d  = part_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
`ifdef DIVZERO_CHK_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    dvd_d  = x_i;
                    div_d  = y_i;
                    part_d = 4'd0;
                    quo_d  = 8'd0;
                    cnt_d  = 3'd0;
                    state_d = S_RUN;
`ifdef DIVZERO_CHK_EN
                    if (y_i == 4'd0) begin
                        state_d = S_DONE;
                        q_d     = 8'hFF;
                        r_d     = 4'h0;
                        dz_d    = 1'b1;
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                dvd_d  = {dvd_q[6:0], 1'b0};
                part_d = part_nx;
                quo_d  = quo_nx;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DONE;
                    q_d     = quo_nx;
                    r_d     = part_nx;
`ifdef DIVZERO_CHK_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            div_q   <= 4'd0;
            part_q  <= 4'd0;
            quo_q   <= 8'd0;
            cnt_q   <= 3'd0;
            q_q     <= 8'd0;
            r_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

`ifdef DIVZERO_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dz_q <= 1'b0;
        else        dz_q <= dz_d;
    end
    assign dz_o = dz_q;
`else
    assign dz_o = 1'b0;
`endif

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign q_o    = q_q;
    assign r_o    = r_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of divisions, back-to-back,
// mid-run reset and an invariant sweep over all nonzero divisors.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = 8'd0;
    logic [3:0] y = 4'd0;
    logic       busy, done, dz;
    logic [7:0] q;
    logic [3:0] r;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .x_i(x), .y_i(y),
        .busy_o(busy), .done_o(done), .q_o(q), .r_o(r), .dz_o(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [3:0] y;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Called at the first falling edge after the start edge; lat counts falling
    // edges until done is seen (9 for a full division).
    task automatic wait_done(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_div(input logic [7:0] xv, input logic [3:0] yv, output int lat, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        x = xv;
        y = yv;
        @(negedge clk);
        start = 1'b0;
        x = 8'($urandom);
        y = 4'($urandom);
        wait_done(lat, busy_n);
    endtask

    vec_t tbl[$];

    initial begin
        int lat, bn, seen;
        logic [7:0] hq;

        tbl.push_back('{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9});
        tbl.push_back('{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9});
        tbl.push_back('{8'd13,  4'd15, 8'd0,   4'd13, 1'b0, 9});
        tbl.push_back('{8'd0,   4'd9,  8'd0,   4'd0,  1'b0, 9});
`ifdef DIVZERO_CHK_EN
        tbl.push_back('{8'd100, 4'd0,  8'hFF,  4'd0,  1'b1, 1});
`else
        tbl.push_back('{8'd100, 4'd0,  8'hFF,  4'd4,  1'b0, 9});
`endif
        tbl.push_back('{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9});
        tbl.push_back('{8'd127, 4'd2,  8'd63,  4'd1,  1'b0, 9});
        tbl.push_back('{8'd1,   4'd15, 8'd0,   4'd1,  1'b0, 9});
        tbl.push_back('{8'd240, 4'd8,  8'd30,  4'd0,  1'b0, 9});
        tbl.push_back('{8'd81,  4'd9,  8'd9,   4'd0,  1'b0, 9});

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_div(tbl[i].x, tbl[i].y, lat, bn);
            check($sformatf("lat[%0d]", i), lat, tbl[i].lat);
            check($sformatf("busy_cycles[%0d]", i), bn, tbl[i].lat - 1);
            check($sformatf("q[%0d]", i), q, tbl[i].q);
            check($sformatf("r[%0d]", i), r, tbl[i].r);
            check($sformatf("dz[%0d]", i), dz, tbl[i].dz);
            @(negedge clk);
            check($sformatf("done_pulse[%0d]", i), done, 0);
            check($sformatf("q_hold[%0d]", i), q, tbl[i].q);
        end

        // start held through RUN with changing operands, then back-to-back restart
        @(negedge clk);
        start = 1'b1;
        x = 8'd200;
        y = 4'd7;
        @(negedge clk);
        x = 8'd50;
        y = 4'd3;
        wait_done(lat, bn);
        check("b2b_lat1", lat, 9);
        check("b2b_q1", q, 28);
        check("b2b_r1", r, 4);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_done", done, 0);
        wait_done(lat, bn);
        check("b2b_lat2", lat, 9);
        check("b2b_q2", q, 16);
        check("b2b_r2", r, 2);

        // Asynchronous reset in the middle of a division
        hq = q;
        check("pre_reset_q_nonzero", (hq != 0), 1);
        @(negedge clk);
        start = 1'b1;
        x = 8'd200;
        y = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_q", q, 0);
        check("arst_r", r, 0);
        check("arst_dz", dz, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no_done_after_abort", seen, 0);
        do_div(8'd81, 4'd9, lat, bn);
        check("post_rst_lat", lat, 9);
        check("post_rst_q", q, 9);
        check("post_rst_r", r, 0);

        // Invariant sweep over every dividend and nonzero divisor
        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 1; yi < 16; yi++) begin
                do_div(8'(xi), 4'(yi), lat, bn);
                check($sformatf("sweep_recon x=%0d y=%0d", xi, yi), 32'(q) * 32'(yi) + 32'(r), 32'(xi));
                check($sformatf("sweep_rlt x=%0d y=%0d", xi, yi), (32'(r) < 32'(yi)), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
